decode_stage: RTL and testbench

- Registered, handshaked successor to the combinational RV32I decoder.
- Sits between fetch and register-read/execute. Accepts {pc, instruction} on a valid/ready interface and emits decoded fields, instruction type, XLEN-wide immediate and an illegal flag one cycle later.
- A 2-entry skid buffer keeps throughput at one instruction per cycle with a registered in_ready.
- Supports pipeline flush and keeps decoded/illegal performance counters.

---
 rtl/decode_stage.sv | 194 +++++++++++++++++++
 tb/tb_decode_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Registered RV32I decode stage with valid/ready handshake,
//            2-entry skid buffer, flush and decoded/illegal counters.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
   parameter int XLEN         = 32,
   parameter int PC_W         = 32,
   parameter int ENABLE_CSR   = 1,
   parameter int ENABLE_FENCE = 1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PC_W-1:0]  in_pc,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [6:0]       out_opcode,
   output logic [4:0]       out_rd,
   output logic [2:0]       out_funct3,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [6:0]       out_funct7,
   output logic [3:0]       out_type,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_illegal,
   output logic [CNT_W-1:0] cnt_decoded,
   output logic [CNT_W-1:0] cnt_illegal
);

   // Instruction type encodings; INVALID is zero so a reset register reads INVALID
   localparam logic [3:0] TYPE_INVALID = 4'd0;
   localparam logic [3:0] TYPE_U       = 4'd1;
   localparam logic [3:0] TYPE_J       = 4'd2;
   localparam logic [3:0] TYPE_I       = 4'd3;
   localparam logic [3:0] TYPE_B       = 4'd4;
   localparam logic [3:0] TYPE_S       = 4'd5;
   localparam logic [3:0] TYPE_R       = 4'd6;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // One buffered, already-decoded instruction
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     instr;
      logic [3:0]      typ;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } entry_t;

   entry_t           main_q, main_d;
   entry_t           skid_q, skid_d;
   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] cnt_decoded_q, cnt_decoded_d;
   logic [CNT_W-1:0] cnt_illegal_q, cnt_illegal_d;

   logic [3:0]       dec_type;
   logic [31:0]      dec_imm32;
   logic [XLEN-1:0]  dec_imm;
   logic             dec_illegal;
   entry_t           dec_entry;
   logic             accept;
   logic             out_xfer;
   logic             main_free;

   // Combinational decode of the incoming word; illegal forces INVALID and imm 0
   always_comb begin
      dec_type  = TYPE_INVALID;
      dec_imm32 = '0;
      unique case (in_instr[6:0])
         OPC_LUI, OPC_AUIPC:           dec_type = TYPE_U;
         OPC_JAL:                      dec_type = TYPE_J;
         OPC_JALR, OPC_LOAD, OPC_OPIMM: dec_type = TYPE_I;
         OPC_FENCE:                    dec_type = (ENABLE_FENCE != 0) ? TYPE_I : TYPE_INVALID;
         OPC_SYSTEM:                   dec_type = (ENABLE_CSR != 0) ? TYPE_I : TYPE_INVALID;
         OPC_BRANCH:                   dec_type = TYPE_B;
         OPC_STORE:                    dec_type = TYPE_S;
         OPC_OP:                       dec_type = TYPE_R;
         default:                      dec_type = TYPE_INVALID;
      endcase
      dec_illegal = (dec_type == TYPE_INVALID);
      unique case (dec_type)
         TYPE_I:  dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         TYPE_S:  dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         TYPE_B:  dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
         TYPE_J:  dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
         TYPE_U:  dec_imm32 = {in_instr[31:12], 12'b0};
         default: dec_imm32 = '0;
      endcase
      // Every 32-bit immediate carries instr[31] in bit 31, so widen by replicating it
      dec_imm       = {XLEN{dec_imm32[31]}};
      dec_imm[31:0] = dec_imm32;
      dec_entry.pc      = in_pc;
      dec_entry.instr   = in_instr;
      dec_entry.typ     = dec_type;
      dec_entry.imm     = dec_imm;
      dec_entry.illegal = dec_illegal;
   end

   assign accept    = in_valid && in_ready_q && !flush;
   assign out_xfer  = main_valid_q && out_ready;
   assign main_free = !main_valid_q || out_xfer;

   // Next-state for the main/skid pair, registered ready and counters
   always_comb begin
      main_d        = main_q;
      skid_d        = skid_q;
      main_valid_d  = main_valid_q;
      skid_valid_d  = skid_valid_q;
      cnt_decoded_d = cnt_decoded_q + CNT_W'(out_xfer);
      cnt_illegal_d = cnt_illegal_q + CNT_W'(out_xfer && main_q.illegal);
      if (skid_valid_q) begin
         // Ready is low while the skid is full, so only draining is possible
         if (out_xfer) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (main_free) begin
            main_d       = dec_entry;
            main_valid_d = 1'b1;
         end else begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
         end
      end else if (out_xfer) begin
         main_valid_d = 1'b0;
      end
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end
      in_ready_d = !skid_valid_d;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q        <= '0;
         skid_q        <= '0;
         main_valid_q  <= 1'b0;
         skid_valid_q  <= 1'b0;
         in_ready_q    <= 1'b1;
         cnt_decoded_q <= '0;
         cnt_illegal_q <= '0;
      end else begin
         main_q        <= main_d;
         skid_q        <= skid_d;
         main_valid_q  <= main_valid_d;
         skid_valid_q  <= skid_valid_d;
         in_ready_q    <= in_ready_d;
         cnt_decoded_q <= cnt_decoded_d;
         cnt_illegal_q <= cnt_illegal_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = main_valid_q;
   assign out_pc      = main_q.pc;
   assign out_opcode  = main_q.instr[6:0];
   assign out_rd      = main_q.instr[11:7];
   assign out_funct3  = main_q.instr[14:12];
   assign out_rs1     = main_q.instr[19:15];
   assign out_rs2     = main_q.instr[24:20];
   assign out_funct7  = main_q.instr[31:25];
   assign out_type    = main_q.typ;
   assign out_imm     = main_q.imm;
   assign out_illegal = main_q.illegal;
   assign cnt_decoded = cnt_decoded_q;
   assign cnt_illegal = cnt_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench for decode_stage; one default instance and
//            one XLEN=64 instance with CSR and FENCE disabled, same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

   localparam logic [3:0] T_INV = 4'd0;
   localparam logic [3:0] T_U   = 4'd1;
   localparam logic [3:0] T_J   = 4'd2;
   localparam logic [3:0] T_I   = 4'd3;
   localparam logic [3:0] T_B   = 4'd4;
   localparam logic [3:0] T_S   = 4'd5;
   localparam logic [3:0] T_R   = 4'd6;

   logic        clk;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_pc, in_instr;

   logic        a_in_ready, a_out_valid, a_ill;
   logic [31:0] a_pc, a_imm, a_cnt_dec, a_cnt_ill;
   logic [6:0]  a_opc, a_f7;
   logic [4:0]  a_rd, a_rs1, a_rs2;
   logic [2:0]  a_f3;
   logic [3:0]  a_type;

   logic        b_in_ready, b_out_valid, b_ill;
   logic [31:0] b_pc, b_cnt_dec, b_cnt_ill;
   logic [63:0] b_imm;
   logic [6:0]  b_opc, b_f7;
   logic [4:0]  b_rd, b_rs1, b_rs2;
   logic [2:0]  b_f3;
   logic [3:0]  b_type;

   decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_pc(a_pc), .out_opcode(a_opc), .out_rd(a_rd), .out_funct3(a_f3), .out_rs1(a_rs1),
      .out_rs2(a_rs2), .out_funct7(a_f7), .out_type(a_type), .out_imm(a_imm),
      .out_illegal(a_ill), .cnt_decoded(a_cnt_dec), .cnt_illegal(a_cnt_ill)
   );

   decode_stage #(.XLEN(64), .PC_W(32), .ENABLE_CSR(0), .ENABLE_FENCE(0), .CNT_W(32)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_pc(b_pc), .out_opcode(b_opc), .out_rd(b_rd), .out_funct3(b_f3), .out_rs1(b_rs1),
      .out_rs2(b_rs2), .out_funct7(b_f7), .out_type(b_type), .out_imm(b_imm),
      .out_illegal(b_ill), .cnt_decoded(b_cnt_dec), .cnt_illegal(b_cnt_ill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the stage behaves as a 2-deep FIFO whose head is the output
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } item_t;

   typedef struct packed {
      logic [3:0]  t;
      logic [63:0] imm;
      logic        il;
   } dec_t;

   item_t       mq[$];
   int unsigned m_dec, m_ill_a, m_ill_b;
   int          checks   = 0;
   int          failures = 0;

   function automatic dec_t ref_decode(input logic [31:0] ins, input bit csr_en, input bit fence_en);
      dec_t   d;
      longint s;
      s     = longint'($signed(ins));
      d.t   = T_INV;
      d.imm = 64'd0;
      case (ins[6:0])
         7'h37, 7'h17:        d.t = T_U;
         7'h6F:               d.t = T_J;
         7'h67, 7'h03, 7'h13: d.t = T_I;
         7'h0F:               d.t = fence_en ? T_I : T_INV;
         7'h73:               d.t = csr_en ? T_I : T_INV;
         7'h63:               d.t = T_B;
         7'h23:               d.t = T_S;
         7'h33:               d.t = T_R;
         default:             d.t = T_INV;
      endcase
      d.il = (d.t == T_INV);
      case (d.t)
         T_I: d.imm = s >>> 20;
         T_S: d.imm = ((s >>> 25) << 5) | longint'(ins[11:7]);
         T_B: d.imm = ((s >>> 31) << 12) | (longint'(ins[7]) << 11)
                      | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
         T_J: d.imm = ((s >>> 31) << 20) | (longint'(ins[19:12]) << 12)
                      | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
         T_U: d.imm = s & ~64'hFFF;
         default: d.imm = 64'd0;
      endcase
      return d;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all();
      dec_t  da, db;
      item_t h;
      chk("a_in_ready", 64'(a_in_ready), 64'(mq.size() < 2));
      chk("b_in_ready", 64'(b_in_ready), 64'(mq.size() < 2));
      chk("a_out_valid", 64'(a_out_valid), 64'(mq.size() > 0));
      chk("b_out_valid", 64'(b_out_valid), 64'(mq.size() > 0));
      chk("a_cnt_decoded", 64'(a_cnt_dec), 64'(m_dec));
      chk("b_cnt_decoded", 64'(b_cnt_dec), 64'(m_dec));
      chk("a_cnt_illegal", 64'(a_cnt_ill), 64'(m_ill_a));
      chk("b_cnt_illegal", 64'(b_cnt_ill), 64'(m_ill_b));
      if (mq.size() > 0) begin
         h  = mq[0];
         da = ref_decode(h.instr, 1'b1, 1'b1);
         db = ref_decode(h.instr, 1'b0, 1'b0);
         chk("a_pc", 64'(a_pc), 64'(h.pc));
         chk("a_fields", 64'({a_f7, a_rs2, a_rs1, a_f3, a_rd, a_opc}), 64'(h.instr));
         chk("a_type", 64'(a_type), 64'(da.t));
         chk("a_imm", 64'(a_imm), 64'(da.imm[31:0]));
         chk("a_illegal", 64'(a_ill), 64'(da.il));
         chk("b_pc", 64'(b_pc), 64'(h.pc));
         chk("b_fields", 64'({b_f7, b_rs2, b_rs1, b_f3, b_rd, b_opc}), 64'(h.instr));
         chk("b_type", 64'(b_type), 64'(db.t));
         chk("b_imm", b_imm, db.imm);
         chk("b_illegal", 64'(b_ill), 64'(db.il));
      end
   endtask

   // One clock: drive inputs, advance the model on the edge, check 1ns later
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, output logic acc);
      logic  xfer;
      item_t h;
      rst = 1'b0; in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl;
      acc  = v && (mq.size() < 2) && !fl;
      xfer = (mq.size() > 0) && rdy;
      @(posedge clk);
      if (xfer) begin
         h = mq.pop_front();
         m_dec++;
         if (ref_decode(h.instr, 1'b1, 1'b1).il) m_ill_a++;
         if (ref_decode(h.instr, 1'b0, 1'b0).il) m_ill_b++;
      end
      if (fl) mq.delete();
      else if (acc) mq.push_back('{pc: pc, instr: ins});
      #1;
      check_all();
   endtask

   task automatic do_reset(input logic v);
      rst = 1'b1; flush = 1'b0; in_valid = v; in_instr = 32'h00500093; in_pc = 32'h40; out_ready = 1'b0;
      @(posedge clk);
      mq.delete();
      m_dec = 0; m_ill_a = 0; m_ill_b = 0;
      #1;
      check_all();
      chk("rst_a_pc", 64'(a_pc), 64'd0);
      chk("rst_a_fields", 64'({a_f7, a_rs2, a_rs1, a_f3, a_rd, a_opc}), 64'd0);
      chk("rst_a_type_imm_ill", 64'({a_type, a_imm, a_ill}), 64'd0);
      chk("rst_b_pc", 64'(b_pc), 64'd0);
      chk("rst_b_fields", 64'({b_f7, b_rs2, b_rs1, b_f3, b_rd, b_opc}), 64'd0);
      chk("rst_b_type_ill", 64'({b_type, b_ill}), 64'd0);
      chk("rst_b_imm", b_imm, 64'd0);
      rst = 1'b0;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [3:0]  ta;
      logic [31:0] imma;
      logic        ila;
      logic [3:0]  tb;
      logic [63:0] immb;
      logic        ilb;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[11];
      logic        acc;
      logic        saw_block;
      int          idx, cyc;
      int unsigned base;
      logic [31:0] r, ins;
      logic [6:0]  opcs[12];

      // Hand-derived expectations: instance a (XLEN=32, CSR/FENCE on), b (XLEN=64, off)
      vt[0]  = '{32'h00500093, 5'd1,  T_I,   32'h00000005, 1'b0, T_I,   64'h0000000000000005, 1'b0};
      vt[1]  = '{32'h12345137, 5'd2,  T_U,   32'h12345000, 1'b0, T_U,   64'h0000000012345000, 1'b0};
      vt[2]  = '{32'h008000EF, 5'd1,  T_J,   32'h00000008, 1'b0, T_J,   64'h0000000000000008, 1'b0};
      vt[3]  = '{32'hFFF00093, 5'd1,  T_I,   32'hFFFFFFFF, 1'b0, T_I,   64'hFFFFFFFFFFFFFFFF, 1'b0};
      vt[4]  = '{32'hFE000EE3, 5'd29, T_B,   32'hFFFFFFFC, 1'b0, T_B,   64'hFFFFFFFFFFFFFFFC, 1'b0};
      vt[5]  = '{32'h00000000, 5'd0,  T_INV, 32'h00000000, 1'b1, T_INV, 64'h0000000000000000, 1'b1};
      vt[6]  = '{32'h00000073, 5'd0,  T_I,   32'h00000000, 1'b0, T_INV, 64'h0000000000000000, 1'b1};
      vt[7]  = '{32'h0000000F, 5'd0,  T_I,   32'h00000000, 1'b0, T_INV, 64'h0000000000000000, 1'b1};
      vt[8]  = '{32'h00112423, 5'd8,  T_S,   32'h00000008, 1'b0, T_S,   64'h0000000000000008, 1'b0};
      vt[9]  = '{32'h40B50533, 5'd10, T_R,   32'h00000000, 1'b0, T_R,   64'h0000000000000000, 1'b0};
      vt[10] = '{32'h80000017, 5'd0,  T_U,   32'h80000000, 1'b0, T_U,   64'hFFFFFFFF80000000, 1'b0};

      opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
      m_dec = 0; m_ill_a = 0; m_ill_b = 0;
      do_reset(1'b0);

      // Back-to-back table vectors with out_ready=1: vector i is visible one clock later
      for (int i = 0; i < 11; i++) begin
         cycle(1'b1, vt[i].instr, 32'h100 + 32'(i * 4), 1'b1, 1'b0, acc);
         chk($sformatf("vec%0d_valid", i), 64'(a_out_valid), 64'd1);
         chk($sformatf("vec%0d_a_rd", i), 64'(a_rd), 64'(vt[i].rd));
         chk($sformatf("vec%0d_a_type", i), 64'(a_type), 64'(vt[i].ta));
         chk($sformatf("vec%0d_a_imm", i), 64'(a_imm), 64'(vt[i].imma));
         chk($sformatf("vec%0d_a_ill", i), 64'(a_ill), 64'(vt[i].ila));
         chk($sformatf("vec%0d_b_type", i), 64'(b_type), 64'(vt[i].tb));
         chk($sformatf("vec%0d_b_imm", i), b_imm, vt[i].immb);
         chk($sformatf("vec%0d_b_ill", i), 64'(b_ill), 64'(vt[i].ilb));
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      chk("vec_cnt_decoded", 64'(a_cnt_dec), 64'd11);
      chk("vec_a_cnt_illegal", 64'(a_cnt_ill), 64'd1);
      chk("vec_b_cnt_illegal", 64'(b_cnt_ill), 64'd3);

      // Six-instruction stream with downstream stalled on stream cycles 2..4
      base = m_dec; idx = 0; cyc = 0; saw_block = 1'b0;
      while (idx < 6 && cyc < 60) begin
         cycle(1'b1, 32'h00100093 + 32'(idx << 20), 32'h200 + 32'(idx * 4),
               !(cyc >= 2 && cyc <= 4), 1'b0, acc);
         if (acc) idx++;
         if (a_in_ready == 1'b0) saw_block = 1'b1;
         cyc++;
      end
      chk("stream_all_accepted", 64'(idx), 64'd6);
      for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      chk("stream_in_ready_dropped", 64'(saw_block), 64'd1);
      chk("stream_cnt_decoded", 64'(a_cnt_dec), 64'(base + 6));

      // Flush with main+skid full and an input presented in the flush cycle
      cycle(1'b1, 32'h00A00113, 32'h300, 1'b0, 1'b0, acc);
      cycle(1'b1, 32'h00B00193, 32'h304, 1'b0, 1'b0, acc);
      chk("flush_pre_in_ready", 64'(a_in_ready), 64'd0);
      base = m_dec;
      cycle(1'b1, 32'h00C00213, 32'h308, 1'b0, 1'b1, acc);
      chk("flush_out_valid", 64'(a_out_valid), 64'd0);
      chk("flush_in_ready", 64'(a_in_ready), 64'd1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      chk("flush_input_dropped", 64'(a_out_valid), 64'd0);
      chk("flush_cnt_unchanged", 64'(a_cnt_dec), 64'(base));

      // Flush with one entry and in_ready=1: input dropped, concurrent transfer counted
      cycle(1'b1, 32'h00000000, 32'h310, 1'b0, 1'b0, acc);
      base = m_dec;
      cycle(1'b1, 32'h00D00293, 32'h314, 1'b1, 1'b1, acc);
      chk("flush_xfer_counted", 64'(a_cnt_dec), 64'(base + 1));
      chk("flush_xfer_out_valid", 64'(a_out_valid), 64'd0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      chk("flush2_input_dropped", 64'(a_out_valid), 64'd0);

      // Randomized traffic against the FIFO model
      for (int k = 0; k < 600; k++) begin
         r   = $urandom();
         ins = {r[31:7], opcs[$urandom_range(0, 11)]};
         cycle(($urandom_range(0, 9) < 7), ins, $urandom(), ($urandom_range(0, 9) < 6),
               ($urandom_range(0, 19) == 0), acc);
      end

      // Reset mid-stream with the skid full
      cycle(1'b1, 32'h00E00313, 32'h400, 1'b0, 1'b0, acc);
      cycle(1'b1, 32'h00F00393, 32'h404, 1'b0, 1'b0, acc);
      cycle(1'b1, 32'h01000413, 32'h408, 1'b0, 1'b0, acc);
      do_reset(1'b1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
